pc_hazard_sequencer: RTL and testbench

- Front-end controller for the 5-stage MIPS pipeline.
- Decides each cycle whether the program counter and the IF/ID and ID/EX pipeline registers advance, hold or flush.
- Selects the next-PC source and drives the ProgramCounter PCWrite enable.
- Sequences load-use stalls, taken branch/jump redirects, multi-cycle multiply occupancy of EX, and a terminal halt.

---
 rtl/pc_hazard_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_hazard_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_hazard_sequencer.sv
// Front-end hazard controller for the 5-stage MIPS pipeline: decides PC / IF/ID / ID/EX
// advance, hold or flush each cycle for load-use, redirects, multi-cycle multiply and halt.
module pc_hazard_sequencer #(
    parameter int MUL_LATENCY = 4,
    parameter int STALL_W     = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               IDEX_MemRead,
    input  logic [4:0]         IDEX_Rt,
    input  logic               IDEX_Mul,
    input  logic [4:0]         IFID_Rs,
    input  logic [4:0]         IFID_Rt,
    input  logic               IFID_UsesRt,
    input  logic               BranchTaken,
    input  logic               Jump,
    input  logic               Halt,
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               IDEXWrite,
    output logic               IFIDFlush,
    output logic               IDEXFlush,
    output logic               EXMEMFlush,
    output logic [1:0]         PCSrc,
    output logic [1:0]         State,
    output logic [STALL_W-1:0] StallCount
);

    localparam int              CNT_W    = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 2);

    typedef enum logic [1:0] {
        S_RUN         = 2'd0,
        S_MUL_BUSY    = 2'd1,
        S_MUL_RELEASE = 2'd2,
        S_HALTED      = 2'd3
    } state_t;

    state_t             r_state, w_next_state;
    logic [CNT_W-1:0]   r_cnt, w_next_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_loaduse, w_mulstall;

    assign w_loaduse  = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                        ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    assign w_mulstall = (r_state == S_RUN) && IDEX_Mul;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            // Halt-bound cycles are excluded so the count reflects hazard stalls only.
            if (!PCWrite && (r_state != S_HALTED) && (w_next_state != S_HALTED) &&
                (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (Halt)            w_next_state = S_HALTED;
                else if (w_mulstall) begin
                    w_next_state = S_MUL_BUSY;
                    w_next_cnt   = CNT_LOAD;
                end
            end
            S_MUL_BUSY: begin
                if (Halt)               w_next_state = S_HALTED;
                else if (r_cnt == '0)   w_next_state = S_MUL_RELEASE;
                else                    w_next_cnt   = r_cnt - CNT_W'(1);
            end
            S_MUL_RELEASE: w_next_state = Halt ? S_HALTED : S_RUN;
            default:       w_next_state = S_HALTED;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        PCSrc      = 2'b00;
        if (!Reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else begin
            case (r_state)
                S_RUN, S_MUL_RELEASE: begin
                    if (Halt) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                    end else if (w_mulstall) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXWrite  = 1'b0;
                        EXMEMFlush = 1'b1;
                    end else if (w_loaduse) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEXFlush = 1'b1;
                    end else if (Jump) begin
                        PCSrc     = 2'b10;
                        IFIDFlush = 1'b1;
                    end else if (BranchTaken) begin
                        PCSrc     = 2'b01;
                        IFIDFlush = 1'b1;
                    end
                end
                S_MUL_BUSY: begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    if (Halt) begin
                        IDEXFlush = 1'b1;
                    end else begin
                        IDEXWrite  = 1'b0;
                        EXMEMFlush = 1'b1;
                    end
                end
                default: begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end
            endcase
        end
    end

    assign State      = r_state;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pc_hazard_sequencer.sv
// Directed bench for pc_hazard_sequencer: a default instance plus a MUL_LATENCY=2,
// STALL_W=4 instance sharing the same stimulus.
module tb_pc_hazard_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IDEX_MemRead, IDEX_Mul, IFID_UsesRt, BranchTaken, Jump, Halt;
    logic [4:0]  IDEX_Rt, IFID_Rs, IFID_Rt;

    logic        pcw_a, ifidw_a, idexw_a, ifidf_a, idexf_a, exmf_a;
    logic [1:0]  pcsrc_a, state_a;
    logic [15:0] cnt_a;
    logic        pcw_b, ifidw_b, idexw_b, ifidf_b, idexf_b, exmf_b;
    logic [1:0]  pcsrc_b, state_b;
    logic [3:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    pc_hazard_sequencer #(.MUL_LATENCY(4), .STALL_W(16)) dut_a (
        .Clk(Clk), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IDEX_Mul(IDEX_Mul), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .BranchTaken(BranchTaken), .Jump(Jump), .Halt(Halt),
        .PCWrite(pcw_a), .IFIDWrite(ifidw_a), .IDEXWrite(idexw_a), .IFIDFlush(ifidf_a),
        .IDEXFlush(idexf_a), .EXMEMFlush(exmf_a), .PCSrc(pcsrc_a), .State(state_a),
        .StallCount(cnt_a)
    );

    pc_hazard_sequencer #(.MUL_LATENCY(2), .STALL_W(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IDEX_Mul(IDEX_Mul), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .BranchTaken(BranchTaken), .Jump(Jump), .Halt(Halt),
        .PCWrite(pcw_b), .IFIDWrite(ifidw_b), .IDEXWrite(idexw_b), .IFIDFlush(ifidf_b),
        .IDEXFlush(idexf_b), .EXMEMFlush(exmf_b), .PCSrc(pcsrc_b), .State(state_b),
        .StallCount(cnt_b)
    );

    // Packed view: {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, PCSrc}
    logic [7:0] out_a, out_b;
    assign out_a = {pcw_a, ifidw_a, idexw_a, ifidf_a, idexf_a, exmf_a, pcsrc_a};
    assign out_b = {pcw_b, ifidw_b, idexw_b, ifidf_b, idexf_b, exmf_b, pcsrc_b};

    localparam logic [7:0] O_FREE   = 8'b1110_0000;
    localparam logic [7:0] O_LDUSE  = 8'b0010_1000;
    localparam logic [7:0] O_HALT   = 8'b0010_1000;
    localparam logic [7:0] O_BRANCH = 8'b1111_0001;
    localparam logic [7:0] O_JUMP   = 8'b1111_0010;
    localparam logic [7:0] O_MUL    = 8'b0000_0100;
    localparam logic [7:0] O_RESET  = 8'b0001_1000;

    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] xrt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
        logic       jmp;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; IDEX_Mul = 1'b0;
        IFID_Rs = 5'd0; IFID_Rt = 5'd0; IFID_UsesRt = 1'b0;
        BranchTaken = 1'b0; Jump = 1'b0; Halt = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        Reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_st_a[6], exp_pw_a[6], exp_st_b[6], exp_pw_b[6];

        vecs[0]  = '{"idle",          1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_FREE};
        vecs[1]  = '{"lduse_rs",      1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, O_LDUSE};
        vecs[2]  = '{"lduse_r0",      1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, O_FREE};
        vecs[3]  = '{"lduse_rt",      1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, O_LDUSE};
        vecs[4]  = '{"rt_not_used",   1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, O_FREE};
        vecs[5]  = '{"no_memread",    1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, O_FREE};
        vecs[6]  = '{"lduse_branch",  1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, O_LDUSE};
        vecs[7]  = '{"branch",        1'b0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, O_BRANCH};
        vecs[8]  = '{"jump",          1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, O_JUMP};
        vecs[9]  = '{"jump_branch",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, O_JUMP};
        vecs[10] = '{"lduse_jump",    1'b1, 5'd31, 5'd1, 5'd31, 1'b1, 1'b0, 1'b1, O_LDUSE};

        // Reset: outputs forced while low, clean RUN state once released
        Reset = 1'b0;
        clear_inputs();
        next_cycle();
        #2;
        check("reset_outputs_a", out_a, O_RESET);
        check("reset_outputs_b", out_b, O_RESET);
        next_cycle();
        Reset = 1'b1;
        #2;
        check("reset_state", state_a, 0);
        check("reset_count", cnt_a, 0);
        check("reset_free_outputs", out_a, O_FREE);

        // Single-cycle vectors in RUN
        for (int i = 0; i < 11; i++) begin
            IDEX_MemRead = vecs[i].mr;  IDEX_Rt = vecs[i].xrt;
            IFID_Rs = vecs[i].rs;       IFID_Rt = vecs[i].rt;
            IFID_UsesRt = vecs[i].uses; BranchTaken = vecs[i].br; Jump = vecs[i].jmp;
            #2;
            check(vecs[i].name, out_a, vecs[i].exp);
            next_cycle();
        end
        clear_inputs();
        #2;
        check("vec_stall_count", cnt_a, 4);
        check("vec_state_run", state_a, 0);

        // One multiply: dut_a stalls 4 cycles (0,1,1,1), dut_b stalls 2 (0,1)
        do_reset();
        exp_st_a = '{0, 1, 1, 1, 2, 0};
        exp_pw_a = '{0, 0, 0, 0, 1, 1};
        exp_st_b = '{0, 1, 2, 0, 0, 0};
        exp_pw_b = '{0, 0, 1, 1, 1, 1};
        IDEX_Mul = 1'b1;
        #2;
        check("mul_first_outputs", out_a, O_MUL);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) #2;
            check($sformatf("mul_state_a_c%0d", c), state_a, exp_st_a[c]);
            check($sformatf("mul_pcw_a_c%0d", c), pcw_a, exp_pw_a[c]);
            check($sformatf("mul_state_b_c%0d", c), state_b, exp_st_b[c]);
            check($sformatf("mul_pcw_b_c%0d", c), pcw_b, exp_pw_b[c]);
            if (c == 4) check("mul_count_a", cnt_a, 4);
            if (c == 2) check("mul_count_b", cnt_b, 2);
            next_cycle();
            IDEX_Mul = 1'b0;
        end

        // Halt during MUL_BUSY: HALTED outputs at once, sticky, count frozen
        do_reset();
        IDEX_Mul = 1'b1;
        next_cycle();
        IDEX_Mul = 1'b0;
        Halt = 1'b1;
        #2;
        check("halt_busy_state", state_a, 1);
        check("halt_busy_outputs", out_a, O_HALT);
        next_cycle();
        Halt = 1'b0;
        BranchTaken = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("halted_state_c%0d", c), state_a, 3);
            check($sformatf("halted_outputs_c%0d", c), out_a, O_HALT);
            check($sformatf("halted_count_c%0d", c), cnt_a, 1);
            next_cycle();
        end
        Reset = 1'b0;
        next_cycle();
        Reset = 1'b1;
        BranchTaken = 1'b0;
        #2;
        check("halt_reset_state", state_a, 0);
        check("halt_reset_pcw", pcw_a, 1);

        // Saturation: 20 load-use stalls
        do_reset();
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd12; IFID_Rs = 5'd12;
        repeat (20) next_cycle();
        clear_inputs();
        #2;
        check("sat_count_b", cnt_b, 15);
        check("sat_count_a", cnt_a, 20);
        check("sat_state", state_a, 0);

        // Halt from RUN: no stall counted, goes to HALTED
        Halt = 1'b1;
        #2;
        check("halt_run_outputs", out_a, O_HALT);
        next_cycle();
        Halt = 1'b0;
        #2;
        check("halt_run_state", state_a, 3);
        check("halt_run_count", cnt_a, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
